// File: rtl/csr_defs_pkg.sv
// Shared CSR-file definitions: CSR numbers, exception codes, CSR op encoding
// and the writeback-commit FSM state type.
package csr_defs_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [5:0] EC_INT = 6'h00;
  localparam logic [5:0] EC_SYS = 6'h0B;
  localparam logic [5:0] EC_BRK = 6'h0C;
  localparam logic [5:0] EC_INE = 6'h0D;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RD   = 2'b01,
    CSR_OP_WR   = 2'b10,
    CSR_OP_XCHG = 2'b11
  } csr_op_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } wb_state_e;

endpackage

// File: rtl/csr_commit_ctrl.sv
// Writeback-stage commit controller: raises exceptions/interrupts/ERTN, drives
// the CSR port, writes back the old CSR value and drains wrong-path work after a redirect.
module csr_commit_ctrl
  import csr_defs_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [5:0]  ECODE_INT    = EC_INT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_valid,
  output logic        ms_ready,
  input  logic [31:0] ms_pc,
  input  logic        ms_ex,
  input  logic [5:0]  ms_ecode,
  input  logic [8:0]  ms_esubcode,
  input  logic        ms_ertn,
  input  logic [1:0]  ms_csr_op,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_csr_wdata,
  input  logic [31:0] ms_csr_mask,
  input  logic [4:0]  ms_dest,
  input  logic        ms_rf_we,
  input  logic        has_int,
  input  logic [31:0] csr_rvalue,
  input  logic [31:0] ex_entry,
  input  logic [31:0] era,
  output logic        csr_re,
  output logic [13:0] csr_num,
  output logic        csr_we,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic [31:0] wb_pc,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic        ertn_flush,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        flush_valid,
  output logic [31:0] flush_pc
);

  wb_state_e   r_state;
  logic [3:0]  r_drain_cnt;
  logic        r_ws_valid;
  logic [31:0] r_ws_pc;
  logic        r_ws_ex;
  logic [5:0]  r_ws_ecode;
  logic [8:0]  r_ws_esubcode;
  logic        r_ws_ertn;
  logic [1:0]  r_ws_csr_op;
  logic [13:0] r_ws_csr_num;
  logic [31:0] r_ws_csr_wdata;
  logic [31:0] r_ws_csr_mask;
  logic [4:0]  r_ws_dest;
  logic        r_ws_rf_we;

  logic w_int;
  logic w_exc;
  logic w_ertn;
  logic w_csr;
  logic w_flush;
  logic w_accept;

  // An interrupt is only taken on a real instruction, and it outranks everything.
  assign w_int    = r_ws_valid & has_int;
  assign w_exc    = w_int | (r_ws_valid & r_ws_ex);
  assign w_ertn   = r_ws_valid & r_ws_ertn & ~w_exc;
  assign w_csr    = r_ws_valid & (r_ws_csr_op != CSR_OP_NONE) & ~w_exc;
  assign w_flush  = w_exc | w_ertn;
  // The beat offered alongside a redirect is wrong-path and is dropped.
  assign w_accept = ms_valid & (r_state == ST_IDLE) & ~w_flush;

  assign ms_ready = 1'b1;

  assign wb_ex       = w_exc;
  assign wb_pc       = w_exc ? r_ws_pc : 32'd0;
  assign wb_ecode    = w_int ? ECODE_INT : (w_exc ? r_ws_ecode : 6'd0);
  assign wb_esubcode = (w_exc & ~w_int) ? r_ws_esubcode : 9'd0;
  assign ertn_flush  = w_ertn;
  assign flush_valid = w_flush;
  assign flush_pc    = w_exc ? ex_entry : (w_ertn ? era : 32'd0);

  assign csr_re     = w_csr;
  assign csr_num    = r_ws_valid ? r_ws_csr_num : 14'd0;
  assign csr_we     = w_csr & r_ws_csr_op[1];
  assign csr_wvalue = w_csr ? r_ws_csr_wdata : 32'd0;
  assign csr_wmask  = !w_csr ? 32'd0 :
                      (r_ws_csr_op == CSR_OP_XCHG) ? r_ws_csr_mask : 32'hFFFF_FFFF;

  // Non-CSR writebacks carry no data through this port; the old CSR value is
  // returned as read, before this cycle's write lands.
  assign rf_we    = r_ws_valid & r_ws_rf_we & ~w_exc;
  assign rf_waddr = r_ws_valid ? r_ws_dest : 5'd0;
  assign rf_wdata = w_csr ? csr_rvalue : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ws_valid     <= 1'b0;
      r_ws_pc        <= 32'd0;
      r_ws_ex        <= 1'b0;
      r_ws_ecode     <= 6'd0;
      r_ws_esubcode  <= 9'd0;
      r_ws_ertn      <= 1'b0;
      r_ws_csr_op    <= 2'd0;
      r_ws_csr_num   <= 14'd0;
      r_ws_csr_wdata <= 32'd0;
      r_ws_csr_mask  <= 32'd0;
      r_ws_dest      <= 5'd0;
      r_ws_rf_we     <= 1'b0;
    end else begin
      r_ws_valid <= w_accept;
      if (w_accept) begin
        r_ws_pc        <= ms_pc;
        r_ws_ex        <= ms_ex;
        r_ws_ecode     <= ms_ecode;
        r_ws_esubcode  <= ms_esubcode;
        r_ws_ertn      <= ms_ertn;
        r_ws_csr_op    <= ms_csr_op;
        r_ws_csr_num   <= ms_csr_num;
        r_ws_csr_wdata <= ms_csr_wdata;
        r_ws_csr_mask  <= ms_csr_mask;
        r_ws_dest      <= ms_dest;
        r_ws_rf_we     <= ms_rf_we;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_flush) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= 4'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == 4'd1) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= 4'd0;
          end else begin
            r_drain_cnt <= r_drain_cnt - 4'd1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_drain_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule
